// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch line buffer.
// Contents: FSM state type and line/instruction geometry constants.
package fetch_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    REFILL = 2'd1,
    READY  = 2'd2
  } fetch_state_e;

  localparam int LINE_BYTES   = 16;
  localparam int LINE_W       = 128;
  localparam int INSTR_W      = 32;
  localparam int WORD_SEL_LSB = 2;

endpackage

// File: rtl/fetch_word_select.sv
// Combinational 128->32 word mux for the fetch line buffer.
// Ports:
//   line_data  in   full cached line, byte at lowest address in the LSBs
//   word_sel   in   word index within the line (pc[3:2])
//   word       out  selected 32-bit instruction
module fetch_word_select
  import fetch_pkg::*;
(
  input  logic [LINE_W-1:0]  line_data,
  input  logic [1:0]         word_sel,
  output logic [INSTR_W-1:0] word
);

  always_comb begin
    word = line_data[INSTR_W-1:0];
    case (word_sel)
      2'd0:    word = line_data[31:0];
      2'd1:    word = line_data[63:32];
      2'd2:    word = line_data[95:64];
      default: word = line_data[127:96];
    endcase
  end

endmodule

// File: rtl/fetch_line_buffer.sv
// Fetch-stage single-line instruction buffer between the PC logic and
// instruction_mem. Serves 32-bit instructions with zero latency on a hit; on
// a miss it issues the line-aligned address, waits MEM_LATENCY edges and
// captures the returned line. stall is held for the whole refill.
//
// Ports:
//   clock, reset_n     clock (rising edge), asynchronous active-low reset
//   pc, pc_valid       requested byte address and request strobe
//   flush              drop the line and abort any refill
//   instr, instr_valid fetched instruction (0 when not valid)
//   stall              request cannot complete this cycle
//   mem_address        registered line-aligned address to instruction_mem
//   mem_dataline       line returned by instruction_mem
//   dbg_state          current FSM state (fetch_state_e encoding)
//   hit_count,
//   miss_count         saturating perf counters (only with FETCH_PERF_CNT_EN)
//
// Handshake: there is no ready/valid pair on this block. A request (pc_valid)
// completes in exactly the cycle instr_valid is high; while stall is high the
// requester must hold pc. The memory side is latency-based, not handshaked.
//
// Optional build macro: FETCH_PERF_CNT_EN adds hit_count/miss_count.
module fetch_line_buffer
  import fetch_pkg::*;
#(
  parameter int MEM_LATENCY = 6,
  parameter int ADDR_W      = 64
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               pc_valid,
  input  logic               flush,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               stall,
  output logic [ADDR_W-1:0]  mem_address,
  input  logic [LINE_W-1:0]  mem_dataline,
  output logic [1:0]         dbg_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
`endif
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_LATENCY - 1);

  fetch_state_e          state_q, state_d;
  logic [LINE_W-1:0]     line_data_q, line_data_d;
  logic [ADDR_W-1:4]     line_tag_q, line_tag_d;
  logic                  line_vld_q, line_vld_d;
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0]     mem_address_q, mem_address_d;

  logic [ADDR_W-1:4]     pc_line;
  logic [ADDR_W-1:4]     mem_line;
  logic                  hit;
  logic                  refill_start;
  logic [INSTR_W-1:0]    sel_word;

  // Byte offset inside a word never affects which instruction is returned.
  logic                  unused_pc_bits;
  assign unused_pc_bits = ^pc[WORD_SEL_LSB-1:0];

  assign pc_line  = pc[ADDR_W-1:4];
  assign mem_line = mem_address_q[ADDR_W-1:4];

  fetch_word_select u_word_select (
    .line_data (line_data_q),
    .word_sel  (pc[WORD_SEL_LSB +: 2]),
    .word      (sel_word)
  );

  always_comb begin
    hit           = line_vld_q & pc_valid & (pc_line == line_tag_q) & ~flush;
    state_d       = state_q;
    line_data_d   = line_data_q;
    line_tag_d    = line_tag_q;
    line_vld_d    = line_vld_q;
    wait_cnt_d    = wait_cnt_q;
    mem_address_d = mem_address_q;
    refill_start  = 1'b0;

    if (flush) begin
      // mem_address deliberately holds; only the line and the FSM are dropped.
      line_vld_d = 1'b0;
      wait_cnt_d = '0;
      state_d    = EMPTY;
    end else begin
      case (state_q)
        EMPTY, READY: begin
          if (pc_valid && !hit) begin
            mem_address_d = {pc_line, 4'b0};
            wait_cnt_d    = '0;
            line_vld_d    = 1'b0;
            state_d       = REFILL;
            refill_start  = 1'b1;
          end
        end
        REFILL: begin
          // Without a request the refill simply freezes in place.
          if (pc_valid) begin
            if (pc_line != mem_line) begin
              // Redirect to a different line: instruction_mem restarts too.
              mem_address_d = {pc_line, 4'b0};
              wait_cnt_d    = '0;
              refill_start  = 1'b1;
            end else if (wait_cnt_q == LAST_WAIT) begin
              line_data_d = mem_dataline;
              line_tag_d  = mem_line;
              line_vld_d  = 1'b1;
              wait_cnt_d  = '0;
              state_d     = READY;
            end else begin
              wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= EMPTY;
      line_data_q   <= '0;
      line_tag_q    <= '0;
      line_vld_q    <= 1'b0;
      wait_cnt_q    <= '0;
      mem_address_q <= '0;
    end else begin
      state_q       <= state_d;
      line_data_q   <= line_data_d;
      line_tag_q    <= line_tag_d;
      line_vld_q    <= line_vld_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_address_q <= mem_address_d;
    end
  end

  // stall is combinational from pc_valid, so it is gated by reset_n to read 0
  // while reset is held even if the requester keeps pc_valid high.
  assign instr_valid = hit & reset_n;
  assign stall       = pc_valid & ~hit & ~flush & reset_n;
  assign instr       = instr_valid ? sel_word : '0;
  assign mem_address = mem_address_q;
  assign dbg_state   = state_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (hit && (hit_count_q != 32'hFFFF_FFFF)) begin
      hit_count_d = hit_count_q + 32'd1;
    end
    if (refill_start && (miss_count_q != 32'hFFFF_FFFF)) begin
      miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  logic unused_refill_start;
  assign unused_refill_start = refill_start;
`endif

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Directed self-checking bench for fetch_line_buffer. The instruction memory
// model returns byte[i]=i for the addressed line, but only once the address
// has been stable long enough; before that it returns a poison pattern.
module tb_fetch_line_buffer;
  import fetch_pkg::*;

  localparam int MEM_LATENCY = 6;
  localparam int ADDR_W      = 64;

  // ---------------- clock / reset ----------------
  logic               clock   = 1'b0;
  logic               reset_n = 1'b0;
  logic [ADDR_W-1:0]  pc       = '0;
  logic               pc_valid = 1'b0;
  logic               flush    = 1'b0;
  logic [31:0]        instr;
  logic               instr_valid;
  logic               stall;
  logic [ADDR_W-1:0]  mem_address;
  logic [127:0]       mem_dataline;
  logic [1:0]         dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]        hit_count;
  logic [31:0]        miss_count;
`endif

  always #5 clock = ~clock;

  fetch_line_buffer #(.MEM_LATENCY(MEM_LATENCY), .ADDR_W(ADDR_W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .flush        (flush),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .stall        (stall),
    .mem_address  (mem_address),
    .mem_dataline (mem_dataline),
    .dbg_state    (dbg_state)
`ifdef FETCH_PERF_CNT_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  // ---------------- memory model ----------------
  logic [ADDR_W-1:0] seen_addr  = '0;
  int unsigned       stable_cnt = 15;

  function automatic logic [127:0] line_of(input logic [ADDR_W-1:0] base);
    logic [127:0] d;
    logic [7:0]   b0;
    b0 = base[7:0];
    for (int j = 0; j < 16; j++) d[8*j +: 8] = b0 + 8'(j);
    return d;
  endfunction

  always @(negedge clock) begin
    if (mem_address != seen_addr) begin
      seen_addr  <= mem_address;
      stable_cnt <= 0;
    end else if (stable_cnt < 15) begin
      stable_cnt <= stable_cnt + 1;
    end
  end

  always_comb begin
    if (stable_cnt >= MEM_LATENCY - 1) mem_dataline = line_of(seen_addr);
    else                               mem_dataline = {4{32'hDEAD_BEEF}};
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [ADDR_W-1:0] a, input logic v, input logic f);
    pc       = a;
    pc_valid = v;
    flush    = f;
  endtask

  // Present a missing pc and follow the full refill to the first hit cycle.
  task automatic run_miss(input logic [ADDR_W-1:0] a, input logic [31:0] exp_instr);
    drive(a, 1'b1, 1'b0);
    for (int i = 0; i <= MEM_LATENCY; i++) begin
      @(negedge clock);
      check_eq("miss_stall", 64'(stall), 64'd1);
      check_eq("miss_no_valid", 64'(instr_valid), 64'd0);
      if (i == 1) check_eq("mem_address", mem_address, {a[ADDR_W-1:4], 4'h0});
      tick();
    end
    @(negedge clock);
    check_eq("miss_valid", 64'(instr_valid), 64'd1);
    check_eq("miss_instr", 64'(instr), 64'(exp_instr));
    check_eq("miss_no_stall", 64'(stall), 64'd0);
    tick();
  endtask

  task automatic hit_word(input logic [ADDR_W-1:0] a, input logic [31:0] exp_instr);
    drive(a, 1'b1, 1'b0);
    @(negedge clock);
    check_eq("hit_valid", 64'(instr_valid), 64'd1);
    check_eq("hit_instr", 64'(instr), 64'(exp_instr));
    check_eq("hit_no_stall", 64'(stall), 64'd0);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [ADDR_W-1:0] hit_addrs [3];
    hit_addrs[0] = 64'h18;
    hit_addrs[1] = 64'h1F;  // low two bits must be ignored
    hit_addrs[2] = 64'h10;

    #3;
    check_eq("rst_instr", 64'(instr), 64'd0);
    check_eq("rst_valid", 64'(instr_valid), 64'd0);
    check_eq("rst_stall", 64'(stall), 64'd0);
    check_eq("rst_mem_address", mem_address, 64'd0);
    check_eq("rst_state", 64'(dbg_state), 64'(EMPTY));
    @(posedge clock);
    #2 reset_n = 1'b1;
    tick();

    // Cold miss then hits in the same line.
    run_miss(64'h14, 32'h1716_1514);
    exp_q.push_back(32'h1B1A_1918);
    exp_q.push_back(32'h1F1E_1D1C);
    exp_q.push_back(32'h1312_1110);
    for (int i = 0; i < 3; i++) begin
      hit_word(hit_addrs[i], exp_q.pop_front());
`ifdef FETCH_PERF_CNT_EN
      if (i == 1) begin
        check_eq("perf_miss", 64'(miss_count), 64'd1);
        check_eq("perf_hit", 64'(hit_count), 64'd3);
      end
`endif
    end

    // Line change mid-refill restarts the wait.
    drive(64'h20, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_eq("restart_pre_stall", 64'(stall), 64'd1);
      tick();
    end
    check_eq("restart_state", 64'(dbg_state), 64'(REFILL));
    run_miss(64'h40, 32'h4342_4140);

    // Flush in refill cycle 4.
    drive(64'h30, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check_eq("flush_pre_stall", 64'(stall), 64'd1);
      tick();
    end
    drive(64'h30, 1'b1, 1'b1);
    @(negedge clock);
    check_eq("flush_valid", 64'(instr_valid), 64'd0);
    check_eq("flush_stall", 64'(stall), 64'd0);
    tick();
    check_eq("flush_state", 64'(dbg_state), 64'(EMPTY));
    run_miss(64'h30, 32'h3332_3130);

    // Top line of the address space, then line 0 must still miss.
    run_miss(64'hFFFF_FFFF_FFFF_FFF8, 32'hFBFA_F9F8);
    hit_word(64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFE_FDFC);
    drive(64'h0, 1'b1, 1'b0);
    @(negedge clock);
    check_eq("nowrap_stall", 64'(stall), 64'd1);
    check_eq("nowrap_valid", 64'(instr_valid), 64'd0);
    tick();
    tick();
    tick();

    // Asynchronous reset mid-refill, pc_valid still high.
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_instr", 64'(instr), 64'd0);
    check_eq("arst_valid", 64'(instr_valid), 64'd0);
    check_eq("arst_stall", 64'(stall), 64'd0);
    check_eq("arst_mem_address", mem_address, 64'd0);
    check_eq("arst_state", 64'(dbg_state), 64'(EMPTY));
`ifdef FETCH_PERF_CNT_EN
    check_eq("arst_hit_count", 64'(hit_count), 64'd0);
    check_eq("arst_miss_count", 64'(miss_count), 64'd0);
`endif
    drive(64'h0, 1'b0, 1'b0);
    @(posedge clock);
    #2 reset_n = 1'b1;
    tick();
    run_miss(64'h10, 32'h1312_1110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000 required");
    $fatal(1, "timeout");
  end

endmodule
